ariane_regfile_lvt_fpga: RTL and testbench
==========================================

// Module: ariane_regfile_lvt_fpga
// PURPOSE
//  Multi-write-port, multi-read-port integer/FP register file for FPGA targets, used by the commit/issue stages.
//  One distributed-RAM bank per write port; a live-value table (LVT) records which bank holds the newest copy of each word.
//  Generalises depth, write-port count and read-port count.
//  Adds a hardware clear sequencer, because distributed RAM has no reset.
//  Adds an optional same-cycle write-to-read bypass.
// PARAMETERS
//  DATA_WIDTH      32  word width in bits
//  ADDR_WIDTH       5  address bits; NUM_WORDS = 2**ADDR_WIDTH
//  NR_READ_PORTS    2  async read ports, >=1
//  NR_WRITE_PORTS   2  sync write ports / RAM banks, >=1; LVT_W = (NR_WRITE_PORTS==1) ? 1 : $clog2(NR_WRITE_PORTS)
//  ZERO_REG_ZERO    0  1: address 0 always reads 0 and writes to it are dropped
// PORTS
//  clk_i         in   1                           clock
//  rst_ni        in   1                           asynchronous active-low reset
//  clear_i       in   1                           request re-initialisation of all words to 0
//  init_done_o   out  1                           1 = file usable; 0 while clearing
//  raddr_i       in   NR_READ_PORTS x ADDR_WIDTH  read addresses
//  rdata_o       out  NR_READ_PORTS x DATA_WIDTH  read data, combinational from raddr_i
//  waddr_i       in   NR_WRITE_PORTS x ADDR_WIDTH write addresses
//  wdata_i       in   NR_WRITE_PORTS x DATA_WIDTH write data
//  we_i          in   NR_WRITE_PORTS              write enables
// BEHAVIOUR
//  - FSM with two states: INIT and READY. Counter clr_cnt is ADDR_WIDTH bits wide.
//  - Reset: state=INIT, clr_cnt=0, LVT all 0, init_done_o=0. rdata_o is 0 while in INIT.
//  - INIT, each cycle: every bank writes 0 at clr_cnt; LVT[clr_cnt]<=0; clr_cnt++.
//    - At clr_cnt==NUM_WORDS-1 the final word is written and state->READY next cycle.
//    - Total INIT duration is exactly NUM_WORDS cycles; init_done_o rises on cycle NUM_WORDS after reset release.
//  - INIT: we_i is ignored; no user write reaches any bank or the LVT.
//  - clear_i in READY: state->INIT, clr_cnt=0 next cycle; same-cycle user writes are dropped.
//  - clear_i in INIT: clr_cnt restarts at 0.
//  - Async reset mid-sequence: immediate return to INIT, clr_cnt=0.
//  - READY write: we_i[j] -> bank j[waddr_i[j]]<=wdata_i[j] and LVT[waddr_i[j]]<=j at the clock edge.
//    - Data is visible on reads from the next cycle (no bypass build).
//  - Simultaneous writes to the same address: highest port index wins in the LVT.
//    - Losing banks still store their data but are never selected for that word.
//  - ZERO_REG_ZERO=1: writes to address 0 update neither bank nor LVT; reads of address 0 return 0.
//  - Read: rdata_o[k] = bank[LVT[raddr_i[k]]][raddr_i[k]]. Purely combinational; no read latency.
//  - Read/write of the same address in one cycle returns the old value, unless the bypass is built.
// CONFIGURATION
//  Macro ARIANE_REGFILE_LVT_BYPASS_EN
//  - Defined: in READY, if any we_i[j] targets raddr_i[k] (and not address 0 when ZERO_REG_ZERO=1):
//    - rdata_o[k] = wdata_i of the highest such j, in the same cycle. Combinational we/waddr/wdata -> rdata path.
//    - No bypass while in INIT.
//  - Undefined: no forwarding; rdata_o reflects only state committed at prior clock edges.
// TESTING
//  1. Reset release, NUM_WORDS=32 -> init_done_o=0 for 32 cycles, 1 on cycle 32; all 32 reads return 0.
//  2. READY, port0 wr addr5=0xA5A5_0001, port1 wr addr5=0x5A5A_0002, same cycle
//     -> next cycle raddr=5 reads 0x5A5A_0002.
//     Then port0 alone writes addr5=0x11 -> reads 0x11.
//  3. ZERO_REG_ZERO=1, write 0xFFFF_FFFF to addr0 -> read addr0 = 0.
//     With ZERO_REG_ZERO=0 the same write reads back 0xFFFF_FFFF.
//  4. Write addr7=0x1234, then clear_i pulse with we_i[0]=1 addr7=0x9999 in the same cycle
//     -> init_done_o low 32 cycles, then addr7 reads 0.
//  5. rst_ni asserted at clr_cnt=10 and released -> full 32-cycle INIT again.
//     we_i held high during INIT has no effect (all reads 0 afterwards).
//  6. Same-cycle write addr3=0xCAFE with raddr=3
//     -> bypass build: rdata_o=0xCAFE that cycle; no-bypass build: old value, 0xCAFE next cycle.

Source files
------------

// File: rtl/ariane_regfile_lvt_fpga.sv
// LVT-based multi-port register file: one distributed-RAM bank per write port, plus a clear sequencer.
// Optional same-cycle write-to-read forwarding when ARIANE_REGFILE_LVT_BYPASS_EN is defined.

module ariane_regfile_lvt_fpga_bank #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned NR_READ_PORTS = 2
) (
  input  logic                                        clk_i,
  input  logic                                        we_i,
  input  logic [ADDR_WIDTH-1:0]                       waddr_i,
  input  logic [DATA_WIDTH-1:0]                       wdata_i,
  input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]    raddr_i,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]    rdata_o
);
  // No reset here so the array maps onto distributed RAM; the clear sequencer zeroes it.
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  for (genvar k = 0; k < NR_READ_PORTS; k++) begin : g_rd
    assign rdata_o[k] = mem_q[raddr_i[k]];
  end
endmodule

module ariane_regfile_lvt_fpga #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter bit          ZERO_REG_ZERO  = 1'b0
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        clear_i,
  output logic                                        init_done_o,
  input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]    raddr_i,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]    rdata_o,
  input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]   waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]                   we_i
);
  localparam int unsigned NUM_WORDS = 2**ADDR_WIDTH;
  localparam int unsigned LVT_W     = (NR_WRITE_PORTS == 1) ? 1 : $clog2(NR_WRITE_PORTS);

  typedef enum logic {INIT, READY} state_e;

  state_e                                   state_q;
  logic [ADDR_WIDTH-1:0]                    clr_cnt_q;
  logic                                     init_done_q;
  logic [NUM_WORDS-1:0][LVT_W-1:0]          lvt_q;

  logic [NR_WRITE_PORTS-1:0]                bank_we_d;
  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] bank_waddr_d;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] bank_wdata_d;
  logic [NR_WRITE_PORTS-1:0][NR_READ_PORTS-1:0][DATA_WIDTH-1:0] bank_rdata;

  function automatic logic zero_hit(input logic [ADDR_WIDTH-1:0] a);
    return ZERO_REG_ZERO && (a == '0);
  endfunction

  // Bank write muxing: the sequencer owns every bank during INIT; a clear request drops user writes.
  always_comb begin
    for (int j = 0; j < NR_WRITE_PORTS; j++) begin
      bank_we_d[j]    = 1'b0;
      bank_waddr_d[j] = clr_cnt_q;
      bank_wdata_d[j] = '0;
      if (state_q == INIT) begin
        bank_we_d[j] = 1'b1;
      end else if (!clear_i && we_i[j] && !zero_hit(waddr_i[j])) begin
        bank_we_d[j]    = 1'b1;
        bank_waddr_d[j] = waddr_i[j];
        bank_wdata_d[j] = wdata_i[j];
      end
    end
  end

  for (genvar j = 0; j < NR_WRITE_PORTS; j++) begin : g_bank
    ariane_regfile_lvt_fpga_bank #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .NR_READ_PORTS (NR_READ_PORTS)
    ) i_bank (
      .clk_i   (clk_i),
      .we_i    (bank_we_d[j]),
      .waddr_i (bank_waddr_d[j]),
      .wdata_i (bank_wdata_d[j]),
      .raddr_i (raddr_i),
      .rdata_o (bank_rdata[j])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      lvt_q       <= '0;
    end else begin
      case (state_q)
        INIT: begin
          lvt_q[clr_cnt_q] <= '0;
          if (clear_i) begin
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_WIDTH'(NUM_WORDS - 1)) begin
              state_q     <= READY;
              init_done_q <= 1'b1;
            end
          end
        end
        default: begin
          if (clear_i) begin
            state_q     <= INIT;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
          end else begin
            // Ascending loop: the highest-index port to the same word is the last assignment and wins.
            for (int j = 0; j < NR_WRITE_PORTS; j++)
              if (bank_we_d[j]) lvt_q[bank_waddr_d[j]] <= LVT_W'(j);
          end
        end
      endcase
    end
  end

  assign init_done_o = init_done_q;

  always_comb begin
    for (int k = 0; k < NR_READ_PORTS; k++) begin
      rdata_o[k] = bank_rdata[lvt_q[raddr_i[k]]][k];
      if (state_q == INIT || zero_hit(raddr_i[k])) rdata_o[k] = '0;
`ifdef ARIANE_REGFILE_LVT_BYPASS_EN
      for (int j = 0; j < NR_WRITE_PORTS; j++)
        if (state_q == READY && we_i[j] && waddr_i[j] == raddr_i[k] && !zero_hit(raddr_i[k]))
          rdata_o[k] = wdata_i[j];
`endif
    end
  end
endmodule

// File: tb/tb_ariane_regfile_lvt_fpga.sv
// Directed bench for ariane_regfile_lvt_fpga; two instances cover ZERO_REG_ZERO = 0 and 1.
module tb_ariane_regfile_lvt_fpga;
  logic              clk_i = 1'b0;
  logic              rst_ni, clear_i;
  logic              done, done_z;
  logic [1:0][4:0]   raddr, waddr;
  logic [1:0][31:0]  wdata, rd, rd_z;
  logic [1:0]        we;
  int                checks = 0, errors = 0;
  logic              any_high;

  always #5 clk_i = ~clk_i;

  ariane_regfile_lvt_fpga #(.ZERO_REG_ZERO(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .init_done_o(done),
    .raddr_i(raddr), .rdata_o(rd), .waddr_i(waddr), .wdata_i(wdata), .we_i(we));

  ariane_regfile_lvt_fpga #(.ZERO_REG_ZERO(1'b1)) dut_z (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .init_done_o(done_z),
    .raddr_i(raddr), .rdata_o(rd_z), .waddr_i(waddr), .wdata_i(wdata), .we_i(we));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // Runs 31 edges expecting init_done low, then one edge expecting it high.
  task automatic expect_init(input string tag);
    any_high = 1'b0;
    for (int i = 0; i < 31; i++) begin
      step();
      any_high |= done | done_z;
    end
    chk({tag, "_low31"}, {31'd0, any_high}, 32'd0);
    step();
    chk({tag, "_rise"}, {30'd0, done_z, done}, 32'd3);
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0;
    #12;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", rd[0], 32'd0);

    // 1: reset release and full clear
    @(posedge clk_i); #1; rst_ni = 1'b1;
    expect_init("init");
    any_high = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr[0] = 5'(a); raddr[1] = 5'(31 - a); #1;
      if (rd[0] !== 32'd0 || rd[1] !== 32'd0 || rd_z[0] !== 32'd0) any_high = 1'b1;
    end
    chk("init_all_zero", {31'd0, any_high}, 32'd0);

    // 2: same-address double write, highest port wins; then single overwrite
    we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5;
    wdata[0] = 32'hA5A5_0001; wdata[1] = 32'h5A5A_0002; raddr[0] = 5'd5; raddr[1] = 5'd5;
    step(); we = '0; #1;
    chk("dual_wr_p0", rd[0], 32'h5A5A_0002);
    chk("dual_wr_p1", rd[1], 32'h5A5A_0002);
    chk("dual_wr_z", rd_z[0], 32'h5A5A_0002);
    we = 2'b01; wdata[0] = 32'h11;
    step(); we = '0; #1;
    chk("p0_overwrite", rd[0], 32'h11);

    // 6: same-cycle read of a word being written
    we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'hCAFE; raddr[0] = 5'd3; #1;
`ifdef ARIANE_REGFILE_LVT_BYPASS_EN
    chk("rw_same_cycle", rd[0], 32'hCAFE);
`else
    chk("rw_same_cycle", rd[0], 32'h0);
`endif
    step(); we = '0; #1;
    chk("rw_next_cycle", rd[0], 32'hCAFE);

    // 3: writes to address 0
    we = 2'b01; waddr[0] = 5'd0; wdata[0] = 32'hFFFF_FFFF; raddr[0] = 5'd0;
    step(); we = '0; #1;
    chk("addr0_nozero", rd[0], 32'hFFFF_FFFF);
    chk("addr0_zero", rd_z[0], 32'h0);

    // 4: clear request drops a same-cycle write
    we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'h1234; raddr[0] = 5'd7;
    step(); we = '0; #1;
    chk("wr7", rd[0], 32'h1234);
    clear_i = 1'b1; we = 2'b01; wdata[0] = 32'h9999;
    step(); clear_i = 1'b0; we = '0; #1;
    chk("clr_done_low", {31'd0, done}, 32'd0);
    chk("clr_rd_init", rd[0], 32'h0);
    any_high = 1'b0;
    for (int i = 0; i < 31; i++) begin
      step(); any_high |= done;
    end
    chk("clr_low31", {31'd0, any_high}, 32'd0);
    step();
    chk("clr_rise", {31'd0, done}, 32'd1);
    chk("clr_rd7", rd[0], 32'h0);

    // 5: reset mid-clear with writes held during INIT
    we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'hBEEF; raddr[0] = 5'd9;
    step(); we = '0; #1;
    chk("wr9", rd[0], 32'hBEEF);
    clear_i = 1'b1; step(); clear_i = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_ni = 1'b0; #1;
    chk("midrst_done", {31'd0, done}, 32'd0);
    step(); rst_ni = 1'b1;
    we = 2'b11; waddr[0] = 5'd9; waddr[1] = 5'd12; wdata[0] = 32'hDEAD; wdata[1] = 32'hF00D;
    expect_init("rst_init");
    we = '0;
    raddr[0] = 5'd9; raddr[1] = 5'd12; #1;
    chk("rst_rd9", rd[0], 32'h0);
    chk("rst_rd12", rd[1], 32'h0);
    raddr[0] = 5'd5; raddr[1] = 5'd3; #1;
    chk("rst_rd5", rd[0], 32'h0);
    chk("rst_rd3", rd[1], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
